// File: rtl/mode_counter_pkg.sv
// Shared types and limits for the mode counter.
// Direction encoding and prescaler width helper.
package mode_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int WIDTH_MIN    = 1;
  localparam int WIDTH_MAX    = 32;
  localparam int PRESCALE_MIN = 1;
  localparam int PRESCALE_MAX = 256;

  // A prescale of 1 still needs a one-bit register.
  function automatic int pre_bits(input int p);
    return (p > 2) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/mode_counter_if.sv
// Control and status bundle of the mode counter.
// clk/rst travel with the bundle for monitors.
interface mode_counter_if #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst
);

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (
    input  clk, rst,
    output en, up_dn, load, load_val, clr_ovf,
    input  count, tc, ovf
  );

  modport slave (
    input  clk, rst,
    input  en, up_dn, load, load_val, clr_ovf,
    output count, tc, ovf
  );

endinterface

// File: rtl/mode_counter_prescaler.sv
// Enable prescaler: step fires every PRESCALE enabled cycles.
// clr restarts the phase and suppresses step.
module mode_counter_prescaler
  import mode_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int PW = pre_bits(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = (pre_q == LAST) ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign step = en & ~clr & (pre_q == LAST);

endmodule

// File: rtl/mode_counter.sv
// Prescaled up/down counter with wrap or saturate at
// the range ends, terminal-count pulse and sticky overflow.
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
  parameter int          PRESCALE = 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  mode_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             at_bnd;
  logic [WIDTH-1:0] load_sat;
  dir_e             dir_w;

  mode_counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_pre (
    .clk (clk),
    .rst (rst),
    .en  (bus.en),
    .clr (bus.load),
    .step(step)
  );

  assign dir_w    = dir_e'(bus.up_dn);
  assign at_bnd   = (dir_w == DIR_UP) ? (count_q == MAX_W)
                                      : (count_q == '0);
  assign load_sat = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;

  // Load and step are exclusive: the prescaler masks step on load.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~bus.clr_ovf;
    unique case (1'b1)
      bus.load: count_d = load_sat;
      step: begin
        if (at_bnd) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (!SATURATE) begin
            count_d = (dir_w == DIR_UP) ? '0 : MAX_W;
          end
        end else begin
          count_d = (dir_w == DIR_UP) ? count_q + WIDTH'(1)
                                      : count_q - WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 Parameter WIDTH, default 8, count register width in bits (1..32).
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1, terminal value of the count range 0..MAX_VAL (1 <= MAX_VAL <= 2**WIDTH-1).
REQ-003 Parameter PRESCALE, default 1, number of enabled cycles per count step (1..256).
REQ-004 Parameter SATURATE, default 0, boundary mode: 0 = wrap, 1 = hold at the boundary.
REQ-005 Port clk, in, 1, single clock; all state is updated on the rising edge.
REQ-006 Port rst, in, 1, asynchronous active-low reset.
REQ-007 Port en, in, 1, count enable; advances the prescaler while high.
REQ-008 Port up_dn, in, 1, direction: 1 = up, 0 = down.
REQ-009 Port load, in, 1, synchronous load strobe.
REQ-010 Port load_val, in, WIDTH, value to load.
REQ-011 Port clr_ovf, in, 1, clears the sticky overflow flag.
REQ-012 Port count, out, WIDTH, current count value, registered.
REQ-013 Port tc, out, 1, terminal-count pulse, registered.
REQ-014 Port ovf, out, 1, sticky boundary-crossing flag, registered.

Function
REQ-015 The internal prescaler pre SHALL count 0..PRESCALE-1 on each clock edge with en=1 and load=0, wrapping to 0 after PRESCALE-1.
REQ-016 A step SHALL occur on the edge where en=1, load=0 and pre==PRESCALE-1; with PRESCALE=1, every enabled edge is a step.
REQ-017 With en=0 and load=0, count, pre and tc SHALL hold, except that tc returns to 0.
REQ-018 Load SHALL have priority over a step: count <= min(load_val, MAX_VAL) and pre <= 0; a load SHALL NOT pulse tc or set ovf.
REQ-019 On an up step with count < MAX_VAL, count SHALL become count+1.
REQ-020 On an up step with count == MAX_VAL, count SHALL become 0 when SATURATE=0, or hold at MAX_VAL when SATURATE=1.
REQ-021 On a down step with count > 0, count SHALL become count-1.
REQ-022 On a down step with count == 0, count SHALL become MAX_VAL when SATURATE=0, or hold at 0 when SATURATE=1.
REQ-023 tc SHALL be 1 for exactly the one cycle following a boundary step (REQ-020 or REQ-022) and 0 otherwise; a repeated boundary step in saturate mode re-pulses tc.
REQ-024 ovf SHALL be set by a boundary step and cleared by clr_ovf; when a set and clr_ovf occur on the same edge, set SHALL win.
REQ-025 Latency: count, tc and ovf SHALL reflect a step or load on the edge that qualifies it, visible in the following cycle.
REQ-026 A change of up_dn mid-prescale SHALL NOT reset pre; the direction is sampled on the step edge only.
REQ-027 All arithmetic SHALL be WIDTH-bit unsigned, with no internal carry beyond MAX_VAL.

Reset
REQ-028 When rst=0, count, pre, tc and ovf SHALL go to 0 asynchronously, independent of clk.
REQ-029 Reset asserted mid-prescale SHALL discard the partial prescale; counting restarts with pre=0 on the first enabled edge after rst deasserts.
REQ-030 Deassertion of rst SHALL be treated as synchronous to clk by the integrator; the block adds no reset synchronizer.

Structure
REQ-031 Package mode_counter_pkg SHALL hold the enum dir_e (DIR_DOWN=0, DIR_UP=1) and the WIDTH/PRESCALE limit constants.
REQ-032 The prescaler SHALL be a sub-module mode_counter_prescaler (ports clk, rst, en, clr, step), with width $clog2(PRESCALE) (minimum 1).
REQ-033 The interface bundle SHALL expose clk and rst as interface ports, in line with the existing counter interface.

Verification
REQ-034 WIDTH=4, MAX_VAL=9, SATURATE=0, PRESCALE=1, up, en held for 12 cycles -> count 0..9,0,1; tc high one cycle after the 9->0 step; ovf=1.
REQ-035 Same configuration, down from reset with en held -> count 0->9 on the first step; tc pulses once; ovf=1.
REQ-036 SATURATE=1, MAX_VAL=9, load_val=8, up, en held for 3 cycles -> count 8->9->9->9; tc pulses on each step at 9; clr_ovf together with a boundary step -> ovf stays 1; clr_ovf alone -> ovf=0.
REQ-037 PRESCALE=4, up, en held 8 cycles -> count steps 0->1->2 on the 4th and 8th enabled edges; en dropped for 2 cycles at pre=2 -> step delayed by 2 cycles.
REQ-038 load=1 with load_val=15 and MAX_VAL=9 on the same edge as a boundary step -> count=9, tc=0, ovf unchanged, pre=0.
REQ-039 rst pulsed low between edges while count=5 and pre=2 -> count, tc and ovf read 0 immediately; the first step after release needs a full PRESCALE cycles.
